sccb_cfg_seq: RTL and testbench

SCCB_CFG_SEQ -- requirements
Module: sccb_cfg_seq

---
 rtl/sccb_cfg_seq.sv | 214 +++++++++++++++++++++
 tb/tb_sccb_cfg_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_cfg_seq.sv
// rtl/sccb_cfg_seq.sv - SCCB register-table configuration sequencer.
// Optional per-entry readback/compare is enabled by defining CFG_READBACK_EN.
module sccb_cfg_seq #(
  parameter logic [7:0] DEV_ID     = 8'h78,
  parameter int         ADDR_BYTES = 2,
  parameter int         REG_NUM    = 285,
  parameter int         DELAY      = 1_000_000,
  localparam int        AW         = (REG_NUM > 1) ? $clog2(REG_NUM) : 1,
  localparam int        TW         = 8 * ADDR_BYTES + 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] tbl_addr,
  input  logic [TW-1:0] tbl_data,
  output logic          req,
  output logic [3:0]    cmd,
  output logic [7:0]    dout,
  input  logic          done,
  input  logic [7:0]    din,
  output logic          busy,
  output logic          config_done,
  output logic [7:0]    err_cnt
);

  localparam int DW = (DELAY > 1) ? $clog2(DELAY) : 1;

  localparam logic [3:0] C_START = 4'b0001;
  localparam logic [3:0] C_WRITE = 4'b0010;
  localparam logic [3:0] C_READ  = 4'b0100;
  localparam logic [3:0] C_STOP  = 4'b1000;

  localparam logic [3:0] S_WAIT  = 4'd0;
  localparam logic [3:0] S_IDLE  = 4'd1;
  localparam logic [3:0] S_FETCH = 4'd2;
  localparam logic [3:0] S_REQ   = 4'd3;
  localparam logic [3:0] S_XFER  = 4'd4;
  localparam logic [3:0] S_NEXT  = 4'd5;
  localparam logic [3:0] S_DONE  = 4'd6;
`ifdef CFG_READBACK_EN
  localparam logic [3:0] S_RREQ  = 4'd7;
  localparam logic [3:0] S_RXFER = 4'd8;
`endif

  logic [3:0]    r_state;
  logic [DW-1:0] r_dly;
  logic [AW-1:0] r_idx;
  logic [2:0]    r_byte;
  logic          r_req;
  logic [3:0]    r_cmd;
  logic [7:0]    r_dout;
  logic          r_cfg_done;

  logic [2:0]    w_sel;
  logic [7:0]    w_addr_byte;
  logic [7:0]    w_data_byte;
  logic          w_last_wr;
  logic [3:0]    w_wr_cmd;
  logic [7:0]    w_wr_dout;

  // Address bytes sit MSB-first above the data byte; r_byte=1 picks the top one.
  assign w_sel       = 3'(ADDR_BYTES + 1) - r_byte;
  assign w_addr_byte = 8'(tbl_data >> {w_sel, 3'b000});
  assign w_data_byte = tbl_data[7:0];
  assign w_last_wr   = (r_byte == 3'(ADDR_BYTES + 1));

  always_comb begin
    w_wr_cmd  = C_START | C_WRITE;
    w_wr_dout = DEV_ID;
    if (w_last_wr) begin
      w_wr_cmd  = C_STOP | C_WRITE;
      w_wr_dout = w_data_byte;
    end else if (r_byte != 3'd0) begin
      w_wr_cmd  = C_WRITE;
      w_wr_dout = w_addr_byte;
    end
  end

`ifdef CFG_READBACK_EN
  logic [7:0] r_err;
  logic       w_last_rb;
  logic [3:0] w_rb_cmd;
  logic [7:0] w_rb_dout;

  assign w_last_rb = (r_byte == 3'(ADDR_BYTES + 2));

  // Readback: re-address the register (STOP on last addr byte), then read it.
  always_comb begin
    w_rb_cmd  = C_START | C_WRITE;
    w_rb_dout = DEV_ID;
    if (w_last_rb) begin
      w_rb_cmd  = C_READ | C_STOP;
      w_rb_dout = 8'h00;
    end else if (r_byte == 3'(ADDR_BYTES + 1)) begin
      w_rb_cmd  = C_START | C_WRITE;
      w_rb_dout = DEV_ID | 8'h01;
    end else if (r_byte != 3'd0) begin
      w_rb_cmd  = (r_byte == 3'(ADDR_BYTES)) ? (C_STOP | C_WRITE) : C_WRITE;
      w_rb_dout = w_addr_byte;
    end
  end

  assign err_cnt = r_err;
`else
  logic w_unused_din;
  assign w_unused_din = ^din;
  assign err_cnt      = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_WAIT;
      r_dly      <= '0;
      r_idx      <= '0;
      r_byte     <= 3'd0;
      r_req      <= 1'b0;
      r_cmd      <= 4'h0;
      r_dout     <= 8'h00;
      r_cfg_done <= 1'b0;
`ifdef CFG_READBACK_EN
      r_err      <= 8'h00;
`endif
    end else begin
      r_req  <= 1'b0;
      r_cmd  <= 4'h0;
      r_dout <= 8'h00;
      case (r_state)
        S_WAIT: begin
          if (r_dly == DW'(DELAY - 1)) begin
            r_dly   <= '0;
            r_idx   <= '0;
            r_state <= S_FETCH;
          end else begin
            r_dly <= r_dly + DW'(1);
          end
        end
        S_IDLE: begin
          if (start) begin
            r_idx      <= '0;
            r_cfg_done <= 1'b0;
`ifdef CFG_READBACK_EN
            r_err      <= 8'h00;
`endif
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_byte  <= 3'd0;
          r_state <= S_REQ;
        end
        S_REQ: begin
          r_req   <= 1'b1;
          r_cmd   <= w_wr_cmd;
          r_dout  <= w_wr_dout;
          r_state <= S_XFER;
        end
        S_XFER: begin
          if (done) begin
            if (w_last_wr) begin
`ifdef CFG_READBACK_EN
              r_byte  <= 3'd0;
              r_state <= S_RREQ;
`else
              r_state <= S_NEXT;
`endif
            end else begin
              r_byte  <= r_byte + 3'd1;
              r_state <= S_REQ;
            end
          end
        end
`ifdef CFG_READBACK_EN
        S_RREQ: begin
          r_req   <= 1'b1;
          r_cmd   <= w_rb_cmd;
          r_dout  <= w_rb_dout;
          r_state <= S_RXFER;
        end
        S_RXFER: begin
          if (done) begin
            if (w_last_rb) begin
              if ((din != w_data_byte) && (r_err != 8'hFF))
                r_err <= r_err + 8'd1;
              r_state <= S_NEXT;
            end else begin
              r_byte  <= r_byte + 3'd1;
              r_state <= S_RREQ;
            end
          end
        end
`endif
        S_NEXT: begin
          if (r_idx == AW'(REG_NUM - 1)) begin
            r_cfg_done <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_idx   <= r_idx + AW'(1);
            r_state <= S_FETCH;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_WAIT;
      endcase
    end
  end

  assign tbl_addr    = r_idx;
  assign req         = r_req;
  assign cmd         = r_cmd;
  assign dout        = r_dout;
  assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign config_done = r_cfg_done;

endmodule

// File: tb/tb_sccb_cfg_seq.sv
// tb/tb_sccb_cfg_seq.sv - directed bench for sccb_cfg_seq (2-byte and 1-byte address instances).
// Readback expectations switch on CFG_READBACK_EN.
`timescale 1ns/1ps
module tb_sccb_cfg_seq;

`ifdef CFG_READBACK_EN
  localparam int         FR0 = 9;
  localparam int         FR1 = 7;
  localparam logic [7:0] EXP_ERR0 = 8'd1;
`else
  localparam int         FR0 = 4;
  localparam int         FR1 = 3;
  localparam logic [7:0] EXP_ERR0 = 8'd0;
`endif
  localparam int N0 = 3 * FR0;
  localparam int N1 = 2 * FR1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start0, start1;
  logic [1:0]  tbl_addr0;
  logic [0:0]  tbl_addr1;
  logic [23:0] tbl_data0;
  logic [15:0] tbl_data1;
  logic        req0, req1, done0, done1, busy0, busy1, cfg0, cfg1;
  logic [3:0]  cmd0, cmd1;
  logic [7:0]  dout0, dout1, din0, din1, err0, err1;

  sccb_cfg_seq #(.DEV_ID(8'h78), .ADDR_BYTES(2), .REG_NUM(3), .DELAY(10)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .tbl_addr(tbl_addr0), .tbl_data(tbl_data0),
    .req(req0), .cmd(cmd0), .dout(dout0), .done(done0), .din(din0),
    .busy(busy0), .config_done(cfg0), .err_cnt(err0));

  sccb_cfg_seq #(.DEV_ID(8'h78), .ADDR_BYTES(1), .REG_NUM(2), .DELAY(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .tbl_addr(tbl_addr1), .tbl_data(tbl_data1),
    .req(req1), .cmd(cmd1), .dout(dout1), .done(done1), .din(din1),
    .busy(busy1), .config_done(cfg1), .err_cnt(err1));

  logic [23:0] tbl0 [4];
  logic [15:0] tbl1 [2];
  initial begin
    tbl0[0] = 24'h300812; tbl0[1] = 24'h310311; tbl0[2] = 24'h3017FF; tbl0[3] = 24'h000000;
    tbl1[0] = 16'h1280;   tbl1[1] = 16'h1100;
  end
  always @(posedge clk) begin
    tbl_data0 <= tbl0[tbl_addr0];
    tbl_data1 <= tbl1[tbl_addr1];
  end

  typedef struct { logic [1:0] addr; logic [3:0] cmd; logic [7:0] dout; int cyc; } rec_t;
  rec_t log0[$], log1[$], exp0[$], exp1[$];
  int   dcyc0[$], dcyc1[$];
  int   cyc;
  int   cnt0 = 0, cnt1 = 0, ovl = 0;
  int   n_chk = 0, n_pass = 0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  // Master models: ack 5 clks after each req; dut0 returns a wrong byte for entry 0.
  always @(negedge clk) begin
    done0 = 1'b0;
    if (!rst_n) cnt0 = 0;
    else begin
      if (cnt0 > 0) begin
        cnt0--;
        if (cnt0 == 0) begin
          done0 = 1'b1;
          din0  = (tbl_addr0 == 2'd0) ? 8'h13 : tbl0[tbl_addr0][7:0];
          dcyc0.push_back(cyc);
        end
      end
      if (req0) begin
        if (cnt0 > 0) ovl++;
        log0.push_back('{tbl_addr0, cmd0, dout0, cyc});
        cnt0 = 5;
      end
    end
  end

  always @(negedge clk) begin
    done1 = 1'b0;
    if (!rst_n) cnt1 = 0;
    else begin
      if (cnt1 > 0) begin
        cnt1--;
        if (cnt1 == 0) begin
          done1 = 1'b1;
          din1  = tbl1[tbl_addr1][7:0];
          dcyc1.push_back(cyc);
        end
      end
      if (req1) begin
        if (cnt1 > 0) ovl++;
        log1.push_back('{{1'b0, tbl_addr1}, cmd1, dout1, cyc});
        cnt1 = 5;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic ev0(input logic [1:0] a, input logic [3:0] c, input logic [7:0] d);
    exp0.push_back('{a, c, d, 0});
  endtask
  task automatic ev1(input logic [1:0] a, input logic [3:0] c, input logic [7:0] d);
    exp1.push_back('{a, c, d, 0});
  endtask

  task automatic wait_n0(input int n);
    int t = 0;
    while (log0.size() < n && t < 3000) begin @(posedge clk); t++; end
    chk("wait_req0", 32'(log0.size() >= n), 1);
  endtask

  task automatic wait_cfg(input bit which);
    int t = 0;
    @(negedge clk);
    while (((which ? cfg1 : cfg0) !== 1'b1) && t < 3000) begin @(negedge clk); t++; end
    chk(which ? "wait_cfg1" : "wait_cfg0", 32'(which ? cfg1 : cfg0), 1);
  endtask

  task automatic check_seq0();
    for (int i = 0; i < N0; i++) begin
      chk($sformatf("seq0[%0d]", i), {log0[i].addr, log0[i].cmd, log0[i].dout},
          {exp0[i].addr, exp0[i].cmd, exp0[i].dout});
      if (i > 0 && (i % FR0) != 0)
        chk($sformatf("gap0[%0d]", i), log0[i].cyc - dcyc0[i-1], 2);
    end
  endtask

  task automatic check_seq1();
    for (int i = 0; i < N1; i++) begin
      chk($sformatf("seq1[%0d]", i), {log1[i].addr, log1[i].cmd, log1[i].dout},
          {exp1[i].addr, exp1[i].cmd, exp1[i].dout});
      if (i > 0 && (i % FR1) != 0)
        chk($sformatf("gap1[%0d]", i), log1[i].cyc - dcyc1[i-1], 2);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req"},  32'(req0), 0);
    chk({tag, "_cmd"},  32'(cmd0), 0);
    chk({tag, "_dout"}, 32'(dout0), 0);
    chk({tag, "_addr"}, 32'(tbl_addr0), 0);
    chk({tag, "_busy"}, 32'(busy0), 1);
    chk({tag, "_cfg"},  32'(cfg0), 0);
    chk({tag, "_err"},  32'(err0), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, t;
    ev0(0,4'h3,8'h78); ev0(0,4'h2,8'h30); ev0(0,4'h2,8'h08); ev0(0,4'hA,8'h12);
`ifdef CFG_READBACK_EN
    ev0(0,4'h3,8'h78); ev0(0,4'h2,8'h30); ev0(0,4'hA,8'h08); ev0(0,4'h3,8'h79); ev0(0,4'hC,8'h00);
`endif
    ev0(1,4'h3,8'h78); ev0(1,4'h2,8'h31); ev0(1,4'h2,8'h03); ev0(1,4'hA,8'h11);
`ifdef CFG_READBACK_EN
    ev0(1,4'h3,8'h78); ev0(1,4'h2,8'h31); ev0(1,4'hA,8'h03); ev0(1,4'h3,8'h79); ev0(1,4'hC,8'h00);
`endif
    ev0(2,4'h3,8'h78); ev0(2,4'h2,8'h30); ev0(2,4'h2,8'h17); ev0(2,4'hA,8'hFF);
`ifdef CFG_READBACK_EN
    ev0(2,4'h3,8'h78); ev0(2,4'h2,8'h30); ev0(2,4'hA,8'h17); ev0(2,4'h3,8'h79); ev0(2,4'hC,8'h00);
`endif
    ev1(0,4'h3,8'h78); ev1(0,4'h2,8'h12); ev1(0,4'hA,8'h80);
`ifdef CFG_READBACK_EN
    ev1(0,4'h3,8'h78); ev1(0,4'hA,8'h12); ev1(0,4'h3,8'h79); ev1(0,4'hC,8'h00);
`endif
    ev1(1,4'h3,8'h78); ev1(1,4'h2,8'h11); ev1(1,4'hA,8'h00);
`ifdef CFG_READBACK_EN
    ev1(1,4'h3,8'h78); ev1(1,4'hA,8'h11); ev1(1,4'h3,8'h79); ev1(1,4'hC,8'h00);
`endif

    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    done0 = 1'b0; done1 = 1'b0; din0 = 8'h00; din1 = 8'h00;
    repeat (3) @(negedge clk);
    reset_checks("rst");
    rst_n = 1'b1;

    // Nominal pass, with a start pulse while busy that must be ignored.
    wait_n0(3);
    @(negedge clk);
    chk("busy_at_ignored_start", 32'(busy0), 1);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_cfg(1'b0);
    chk("done_busy0", 32'(busy0), 0);
    wait_cfg(1'b1);
    repeat (3) @(negedge clk);
    chk("first_req_cyc0", log0[0].cyc, 12);
    chk("first_req_cyc1", log1[0].cyc, 12);
    chk("nreq0", log0.size(), N0);
    chk("nreq1", log1.size(), N1);
    chk("idle_busy0", 32'(busy0), 0);
    chk("err0", 32'(err0), 32'(EXP_ERR0));
    chk("err1", 32'(err1), 0);
    chk("cfg1_held", 32'(cfg1), 1);
    check_seq0();
    check_seq1();

    // Start in IDLE: immediate restart, no power-up delay.
    log0.delete(); dcyc0.delete();
    @(negedge clk);
    c0 = cyc;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("restart_cfg_clr", 32'(cfg0), 0);
    chk("restart_err_clr", 32'(err0), 0);
    chk("restart_busy", 32'(busy0), 1);
    chk("restart_addr", 32'(tbl_addr0), 0);
    wait_cfg(1'b0);
    repeat (3) @(negedge clk);
    chk("restart_latency", log0[0].cyc - c0, 3);
    chk("restart_nreq", log0.size(), N0);
    chk("restart_err", 32'(err0), 32'(EXP_ERR0));
    check_seq0();

    // Reset mid-frame after the 2nd done, while req is high.
    log0.delete(); dcyc0.delete();
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    t = 0;
    while (dcyc0.size() < 2 && t < 3000) begin @(posedge clk); t++; end
    chk("wait_2nd_done", 32'(dcyc0.size() >= 2), 1);
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!req0 && t < 100);
    chk("req_before_reset", 32'(req0), 1);
    #1 rst_n = 1'b0;
    #1 reset_checks("async_rst");
    repeat (2) @(negedge clk);
    log0.delete(); dcyc0.delete(); log1.delete(); dcyc1.delete();
    rst_n = 1'b1;
    wait_n0(1);
    chk("post_rst_first_req", log0[0].cyc, 12);
    wait_cfg(1'b0);
    repeat (3) @(negedge clk);
    chk("post_rst_nreq", log0.size(), N0);
    check_seq0();
    chk("req_overlap", ovl, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
